ifu_prefetch: RTL and testbench

//  Parametrised instruction-fetch unit with a prefetch queue. Owns the fetch PC and issues

---
 rtl/ifu_prefetch.sv | 130 +++++++++++++
 tb/tb_ifu_prefetch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with a credited prefetch queue.
//   Owns the fetch PC and issues pipelined in-order requests to instruction memory.
//   Returned words are queued with their PCs and handed to the IDU (valid/ready).
//   A redirect flushes the queue and marks every in-flight response as stale.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_req_o / imem_addr_o    fetch request and word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i/imem_rdata_i  one in-order response per grant
//   redirect_i / redirect_pc_i  flush and restart fetch at the new PC
//   inst_valid_o/inst_o/inst_pc_o  queue head toward the IDU
//   inst_ready_i                IDU consumes the head
module ifu_prefetch #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(2 * FIFO_DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_pend;
  logic [PW-1:0]   r_drop;
  logic [ILEN-1:0] r_mem_data [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_pc   [FIFO_DEPTH];

  logic [PW-1:0]   w_inflight;
  logic            w_credit_ok;
  logic            w_grant;
  logic            w_push;
  logic            w_pop;
  logic            w_head_ok;
  logic [XLEN-1:0] w_redirect_pc;

  // Live requests are pend minus the stale ones; queued plus live never exceeds the depth,
  // which is what guarantees every delivered word has a free slot.
  assign w_inflight  = r_pend - r_drop;
  assign w_credit_ok = (PW'(r_count) + w_inflight) < PW'(FIFO_DEPTH);

  assign imem_req_o  = !reset && !redirect_i && w_credit_ok;
  assign imem_addr_o = r_fetch_pc;
  assign w_grant     = imem_req_o && imem_gnt_i;

  // Stale responses are swallowed while drop is non-zero; redirect-cycle responses too.
  assign w_push = !reset && !redirect_i && imem_rvalid_i && (r_drop == '0);

  // Head is forced to zero whenever the queue is empty so reset outputs are clean.
  assign w_head_ok    = !reset && (r_count != '0);
  assign inst_valid_o = w_head_ok && !redirect_i;
  assign inst_o       = w_head_ok ? r_mem_data[r_rd_ptr] : '0;
  assign inst_pc_o    = w_head_ok ? r_mem_pc[r_rd_ptr]   : '0;
  assign w_pop        = inst_valid_o && inst_ready_i;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);

  // Queue storage, no reset needed: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_rdata_i;
      r_mem_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  // Control state: PCs, queue occupancy, outstanding and stale request counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pend     <= '0;
      r_drop     <= '0;
    end else if (redirect_i) begin
      // No grant can occur here, so pend only loses this cycle's response;
      // everything still outstanding becomes stale.
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pend     <= r_pend - PW'(imem_rvalid_i);
      r_drop     <= r_pend - PW'(imem_rvalid_i);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      r_pend <= r_pend + PW'(w_grant) - PW'(imem_rvalid_i);
      if (imem_rvalid_i && (r_drop != '0)) begin
        r_drop <= r_drop - PW'(1);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // The credit rule makes these unreachable with a well-behaved memory.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && (r_count == CW'(FIFO_DEPTH))));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid_i && (r_pend == '0)));

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed bench for ifu_prefetch with a small in-order memory model.
module tb_ifu_prefetch;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  // Second instance for the PC wrap case: always granted, never answered.
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_gnt;
  logic        wr_rvalid;
  logic [31:0] wr_rdata;
  logic        wr_redirect;
  logic [31:0] wr_redirect_pc;
  logic        wr_valid;
  logic [31:0] wr_inst;
  logic [31:0] wr_inst_pc;
  logic        wr_ready;

  int          total;
  int          bad;
  int          grants;
  bit          rsp_en;
  logic [31:0] mq[$];

  ifu_prefetch #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  ifu_prefetch #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_o(wr_req), .imem_addr_o(wr_addr), .imem_gnt_i(wr_gnt),
    .imem_rvalid_i(wr_rvalid), .imem_rdata_i(wr_rdata),
    .redirect_i(wr_redirect), .redirect_pc_i(wr_redirect_pc),
    .inst_valid_o(wr_valid), .inst_o(wr_inst), .inst_pc_o(wr_inst_pc),
    .inst_ready_i(wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: record the grant, then answer the oldest request (word = ~addr) after the edge.
  task automatic step();
    logic        g;
    logic [31:0] a;
    #1;
    g = imem_req_o && imem_gnt_i;
    a = imem_addr_o;
    if (g) grants++;
    @(posedge clk);
    if (reset) mq.delete();
    else if (g) mq.push_back(a);
    @(negedge clk);
    if (!reset && rsp_en && mq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ~mq.pop_front();
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_gnt_i = 1'b0; inst_ready_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    rsp_en = 1'b1; mq.delete();
    step();
    reset = 1'b0;
    grants = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_gnt_i = 1'b0; inst_ready_i = 1'b0;
    redirect_i = 1'b0; imem_rvalid_i = 1'b0; mq.delete();
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req_during got=%0h exp=0", imem_req_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid_during got=%0h exp=0", inst_valid_o); end
    step();
    reset = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rst_req_after got=%0h exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", imem_addr_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", inst_valid_o); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst got=%0h exp=0", inst_o); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL rst_inst_pc got=%0h exp=0", inst_pc_o); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = 32'(4 * k);
      total++; if (imem_addr_o !== e) begin bad++; $display("FAIL stream_addr k=%0d got=%0h exp=%0h", k, imem_addr_o, e); end
      if (k >= 2) begin
        e = 32'(4 * (k - 2));
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid k=%0d got=%0h exp=1", k, inst_valid_o); end
        total++; if (inst_pc_o !== e) begin bad++; $display("FAIL stream_pc k=%0d got=%0h exp=%0h", k, inst_pc_o, e); end
        total++; if (inst_o !== ~e) begin bad++; $display("FAIL stream_inst k=%0d got=%0h exp=%0h", k, inst_o, ~e); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b0;
    repeat (8) step();
    #1;
    total++; if (grants !== 4) begin bad++; $display("FAIL bp_grants got=%0d exp=4", grants); end
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL bp_req_full got=%0h exp=0", imem_req_o); end
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid got=%0h exp=1", inst_valid_o); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%0h exp=0", inst_pc_o); end
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL bp_req_after_pop got=%0h exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 32'h10) begin bad++; $display("FAIL bp_addr_after_pop got=%0h exp=10", imem_addr_o); end
    total++; if (inst_pc_o !== 32'h4) begin bad++; $display("FAIL bp_head_pc2 got=%0h exp=4", inst_pc_o); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    rsp_en = 1'b0; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    step(); step();
    rsp_en = 1'b1;
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rd_req_in_redirect got=%0h exp=0", imem_req_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_in_redirect got=%0h exp=0", inst_valid_o); end
    step();
    redirect_i = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rd_req_resume got=%0h exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 32'h100) begin bad++; $display("FAIL rd_addr_resume got=%0h exp=100", imem_addr_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_c4 got=%0h exp=0", inst_valid_o); end
    step();
    #1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_c5 got=%0h exp=0", inst_valid_o); end
    total++; if (imem_addr_o !== 32'h104) begin bad++; $display("FAIL rd_addr_c5 got=%0h exp=104", imem_addr_o); end
    step();
    #1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rd_valid_c6 got=%0h exp=0", inst_valid_o); end
    step();
    #1;
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL rd_valid_c7 got=%0h exp=1", inst_valid_o); end
    total++; if (inst_pc_o !== 32'h100) begin bad++; $display("FAIL rd_first_pc got=%0h exp=100", inst_pc_o); end
    total++; if (inst_o !== ~32'h100) begin bad++; $display("FAIL rd_first_inst got=%0h exp=%0h", inst_o, ~32'h100); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    imem_gnt_i = 1'b1; inst_ready_i = 1'b0;
    step(); step(); step();
    #1;
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL fl_valid_before got=%0h exp=1", inst_valid_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    #1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid_same_cycle got=%0h exp=0", inst_valid_o); end
    step();
    redirect_i = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid_after got=%0h exp=0", inst_valid_o); end
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL fl_req_after got=%0h exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 32'h100) begin bad++; $display("FAIL fl_addr_aligned got=%0h exp=100", imem_addr_o); end
    inst_ready_i = 1'b1;
    step(); step();
    #1;
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL fl_valid_new got=%0h exp=1", inst_valid_o); end
    total++; if (inst_pc_o !== 32'h100) begin bad++; $display("FAIL fl_pc_new got=%0h exp=100", inst_pc_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%0h exp=1", wr_req); end
    total++; if (wr_addr !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_addr0 got=%0h exp=fffffff8", wr_addr); end
    step();
    #1;
    total++; if (wr_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr1 got=%0h exp=fffffffc", wr_addr); end
    step();
    #1;
    total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr2 got=%0h exp=0", wr_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_en = 1'b0; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    step(); step();
    #1;
    total++; if (imem_addr_o !== 32'h8) begin bad++; $display("FAIL rm_addr_pre got=%0h exp=8", imem_addr_o); end
    reset = 1'b1; imem_rvalid_i = 1'b0; mq.delete();
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rm_req_during got=%0h exp=0", imem_req_o); end
    step();
    reset = 1'b0; rsp_en = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL rm_req_after got=%0h exp=1", imem_req_o); end
    total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL rm_addr_after got=%0h exp=0", imem_addr_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rm_valid_after got=%0h exp=0", inst_valid_o); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rm_inst_after got=%0h exp=0", inst_o); end
    step(); step();
    #1;
    total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL rm_valid_restart got=%0h exp=1", inst_valid_o); end
    total++; if (inst_pc_o !== 32'h0) begin bad++; $display("FAIL rm_pc_restart got=%0h exp=0", inst_pc_o); end
    total++; if (inst_o !== ~32'h0) begin bad++; $display("FAIL rm_inst_restart got=%0h exp=ffffffff", inst_o); end
  endtask

  initial begin
    total = 0; bad = 0; grants = 0; rsp_en = 1'b1;
    reset = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
    wr_gnt = 1'b1; wr_rvalid = 1'b0; wr_rdata = '0;
    wr_redirect = 1'b0; wr_redirect_pc = '0; wr_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
